// File: rtl/trig_conditioner.sv
// Trigger input conditioner: synchronises and debounces a raw input, detects the selected
// edge, and issues a one-cycle TRG_ONE with optional retrigger holdoff and a saturating count.
module trig_conditioner #(
    parameter logic [15:0] DB_CYCLES = 16'd16,
    parameter logic [7:0]  HOLDOFF   = 8'd0
) (
    input  logic       CLK,
    input  logic       R_N,
    input  logic       BTN,
    input  logic       EN,
    input  logic [1:0] EDGE_SEL,
    input  logic       CLR_CNT,
    output logic       TRG_ONE,
    output logic       LEVEL,
    output logic       BUSY,
    output logic [7:0] CNT
);

    localparam logic [15:0] DB_LAST = DB_CYCLES - 16'd1;

    logic        s1;
    logic        s2;
    logic        level_d;
    logic [15:0] db_cnt;
    logic [7:0]  hold_cnt;
    logic        rise;
    logic        fall;
    logic        ev;
    logic        fire;

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
        end
    end

    // Any synchronised sample that agrees with LEVEL restarts the debounce count.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            LEVEL   <= 1'b0;
            level_d <= 1'b0;
            db_cnt  <= 16'd0;
        end else begin
            level_d <= LEVEL;
            if (s2 == LEVEL) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == DB_LAST) begin
                LEVEL  <= s2;
                db_cnt <= 16'd0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        rise = LEVEL & ~level_d;
        fall = ~LEVEL & level_d;
        case (EDGE_SEL)
            2'b00:   ev = rise;
            2'b01:   ev = fall;
            2'b10:   ev = rise | fall;
            default: ev = 1'b0;
        endcase
        fire = ev & EN & (hold_cnt == 8'd0);
    end

    // Edges arriving while the holdoff window is open are dropped, never queued.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            TRG_ONE  <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            TRG_ONE <= fire;
            if (fire) begin
                hold_cnt <= HOLDOFF;
            end else if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    // Clear wins over a trigger issued on the same edge.
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            CNT <= 8'd0;
        end else if (CLR_CNT) begin
            CNT <= 8'd0;
        end else if (fire && (CNT != 8'hFF)) begin
            CNT <= CNT + 8'd1;
        end
    end

    assign BUSY = (hold_cnt != 8'd0);

endmodule

// File: tb/tb_trig_conditioner.sv
// Directed bench for trig_conditioner: instance A runs without holdoff, instance B with a
// ten-cycle holdoff; both debounce over four samples.
module tb_trig_conditioner;

    logic       CLK;
    logic       a_rst_n, a_btn, a_en, a_clr;
    logic [1:0] a_sel;
    logic       a_trg, a_level, a_busy;
    logic [7:0] a_cnt;
    logic       b_rst_n, b_btn, b_en, b_clr;
    logic [1:0] b_sel;
    logic       b_trg, b_level, b_busy;
    logic [7:0] b_cnt;

    int checks = 0;
    int passes = 0;
    int a_pulses = 0;

    trig_conditioner #(.DB_CYCLES(16'd4), .HOLDOFF(8'd0)) u_a (
        .CLK(CLK), .R_N(a_rst_n), .BTN(a_btn), .EN(a_en), .EDGE_SEL(a_sel),
        .CLR_CNT(a_clr), .TRG_ONE(a_trg), .LEVEL(a_level), .BUSY(a_busy), .CNT(a_cnt)
    );

    trig_conditioner #(.DB_CYCLES(16'd4), .HOLDOFF(8'd10)) u_b (
        .CLK(CLK), .R_N(b_rst_n), .BTN(b_btn), .EN(b_en), .EDGE_SEL(b_sel),
        .CLR_CNT(b_clr), .TRG_ONE(b_trg), .LEVEL(b_level), .BUSY(b_busy), .CNT(b_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (a_trg === 1'b1) a_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        a_rst_n = 1'b0; a_btn = 1'b0; a_en = 1'b1; a_sel = 2'b00; a_clr = 1'b0;
        b_rst_n = 1'b0; b_btn = 1'b0; b_en = 1'b1; b_sel = 2'b10; b_clr = 1'b0;
        step(2);
        check_output("rst_trg", 16'(a_trg), 16'd0);
        check_output("rst_level", 16'(a_level), 16'd0);
        check_output("rst_busy", 16'(b_busy), 16'd0);
        check_output("rst_cnt", 16'(a_cnt), 16'd0);
        @(negedge CLK);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step(2);

        // Rising edge: LEVEL moves at edge k+5, TRG_ONE follows one edge later.
        a_btn = 1'b1;
        step(5);
        check_output("t1_level_early", 16'(a_level), 16'd0);
        step(1);
        check_output("t1_level", 16'(a_level), 16'd1);
        check_output("t1_trg_early", 16'(a_trg), 16'd0);
        step(1);
        check_output("t1_trg", 16'(a_trg), 16'd1);
        check_output("t1_cnt", 16'(a_cnt), 16'd1);
        check_output("t1_busy", 16'(a_busy), 16'd0);
        step(1);
        check_output("t1_trg_once", 16'(a_trg), 16'd0);

        a_btn = 1'b0;
        step(7);
        check_output("t1_fall_level", 16'(a_level), 16'd0);
        check_output("t1_fall_notrg", 16'(a_cnt), 16'd1);
        step(3);

        // Glitches of 1..3 cycles never reach LEVEL.
        for (int n = 1; n <= 3; n++) begin
            a_btn = 1'b1;
            step(n);
            a_btn = 1'b0;
            step(8);
            check_output("t2_glitch_level", 16'(a_level), 16'd0);
        end
        check_output("t2_glitch_pulses", 16'(a_pulses), 16'd1);
        check_output("t2_glitch_cnt", 16'(a_cnt), 16'd1);

        a_btn = 1'b1;
        step(4);
        a_btn = 1'b0;
        step(2);
        check_output("t2_stable4_level", 16'(a_level), 16'd1);
        step(1);
        check_output("t2_stable4_trg", 16'(a_trg), 16'd1);
        check_output("t2_stable4_cnt", 16'(a_cnt), 16'd2);
        step(8);
        check_output("t2_return_level", 16'(a_level), 16'd0);

        // Edge selection and enable.
        a_btn = 1'b1; step(10);
        check_output("t3_rise_cnt", 16'(a_cnt), 16'd3);
        a_btn = 1'b0; step(10);
        check_output("t3_fall_ignored", 16'(a_cnt), 16'd3);
        a_sel = 2'b10;
        a_btn = 1'b1; step(10);
        a_btn = 1'b0; step(10);
        check_output("t3_both_cnt", 16'(a_cnt), 16'd5);
        check_output("t3_both_pulses", 16'(a_pulses), 16'd5);
        a_sel = 2'b11;
        a_btn = 1'b1; step(10);
        check_output("t3_none_level", 16'(a_level), 16'd1);
        a_btn = 1'b0; step(10);
        check_output("t3_none_cnt", 16'(a_cnt), 16'd5);
        a_sel = 2'b10;
        a_en = 1'b0;
        a_btn = 1'b1; step(10);
        check_output("t3_en0_level", 16'(a_level), 16'd1);
        a_btn = 1'b0; step(10);
        check_output("t3_en0_level_back", 16'(a_level), 16'd0);
        check_output("t3_en0_cnt", 16'(a_cnt), 16'd5);
        a_en = 1'b1;

        // Saturation after 260 more accepted edges.
        for (int i = 0; i < 260; i++) begin
            a_btn = ~a_btn;
            step(7);
        end
        check_output("t5_sat_cnt", 16'(a_cnt), 16'hFF);
        check_output("t5_sat_level", 16'(a_level), 16'd0);

        a_btn = 1'b1;
        step(6);
        check_output("t5_clr_prelevel", 16'(a_level), 16'd1);
        a_clr = 1'b1;
        step(1);
        check_output("t5_clr_trg", 16'(a_trg), 16'd1);
        check_output("t5_clr_cnt", 16'(a_cnt), 16'd0);
        a_clr = 1'b0;
        step(1);
        check_output("t5_clr_hold", 16'(a_cnt), 16'd0);
        a_btn = 1'b0;
        step(7);
        check_output("t5_recount", 16'(a_cnt), 16'd1);

        // Holdoff on instance B (both edges selected).
        b_btn = 1'b1;
        step(6);
        check_output("t4_level", 16'(b_level), 16'd1);
        b_btn = 1'b0;
        step(1);
        check_output("t4_trg", 16'(b_trg), 16'd1);
        check_output("t4_busy_start", 16'(b_busy), 16'd1);
        step(5);
        check_output("t4_level_fall", 16'(b_level), 16'd0);
        step(1);
        check_output("t4_dropped_trg", 16'(b_trg), 16'd0);
        check_output("t4_dropped_cnt", 16'(b_cnt), 16'd1);
        step(3);
        check_output("t4_busy_last", 16'(b_busy), 16'd1);
        step(1);
        check_output("t4_busy_end", 16'(b_busy), 16'd0);

        // Edge arriving on the first cycle with holdoff expired.
        b_btn = 1'b1;
        step(7);
        check_output("t4_second_trg", 16'(b_trg), 16'd1);
        check_output("t4_second_cnt", 16'(b_cnt), 16'd2);
        step(4);
        b_btn = 1'b0;
        step(5);
        check_output("t4_edge_busy", 16'(b_busy), 16'd1);
        step(1);
        check_output("t4_edge_idle", 16'(b_busy), 16'd0);
        check_output("t4_edge_level", 16'(b_level), 16'd0);
        step(1);
        check_output("t4_boundary_trg", 16'(b_trg), 16'd1);
        check_output("t4_boundary_cnt", 16'(b_cnt), 16'd3);

        // Bring CNT to 5 with LEVEL high, then reset mid-holdoff.
        step(10);
        b_btn = 1'b1; step(7);
        check_output("t6_cnt4", 16'(b_cnt), 16'd4);
        b_sel = 2'b00;
        b_btn = 1'b0; step(7);
        check_output("t6_fall_ignored", 16'(b_cnt), 16'd4);
        step(4);
        b_btn = 1'b1; step(7);
        check_output("t6_pre_trg", 16'(b_trg), 16'd1);
        check_output("t6_pre_cnt", 16'(b_cnt), 16'd5);
        check_output("t6_pre_busy", 16'(b_busy), 16'd1);
        #2;
        b_rst_n = 1'b0;
        #1;
        check_output("t6_rst_trg", 16'(b_trg), 16'd0);
        check_output("t6_rst_busy", 16'(b_busy), 16'd0);
        check_output("t6_rst_level", 16'(b_level), 16'd0);
        check_output("t6_rst_cnt", 16'(b_cnt), 16'd0);
        @(negedge CLK);
        b_rst_n = 1'b1;
        step(5);
        check_output("t6_rel_level_early", 16'(b_level), 16'd0);
        step(1);
        check_output("t6_rel_level", 16'(b_level), 16'd1);
        check_output("t6_rel_trg_early", 16'(b_trg), 16'd0);
        step(1);
        check_output("t6_rel_trg", 16'(b_trg), 16'd1);
        check_output("t6_rel_cnt", 16'(b_cnt), 16'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
